// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed display scanner.
package disp_pkg;
   localparam int DEF_NUM_DIGITS = 8;
   localparam int DEF_DIGIT_W    = 4;
   localparam int DEF_SCAN_DIV   = 1000;
   localparam int DEF_PWM_BITS   = 4;
   // Digit code treated as "zero" for leading-zero blanking.
   localparam int BLANK_CODE     = 0;
endpackage

// File: rtl/scan_tick.sv
// Slot prescaler: counts 0..DIV-1 and raises tick in the wrapping cycle.
module scan_tick
   import disp_pkg::*;
#(
   parameter int DIV = DEF_SCAN_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/disp_scan.sv
// Multiplexed digit scanner with shadow/active frame buffering,
// leading-zero blanking and PWM brightness gating.
module disp_scan
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int SCAN_DIV   = DEF_SCAN_DIV,
   parameter int PWM_BITS   = DEF_PWM_BITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
   input  logic [NUM_DIGITS-1:0]         dp_mask,
   input  logic                          load,
   input  logic [PWM_BITS-1:0]           brightness,
   input  logic                          lz_suppress,
   output logic [DIGIT_W-1:0]            digit_val,
   output logic [NUM_DIGITS-1:0]         digit_sel,
   output logic                          dp,
   output logic                          digit_on,
   output logic                          frame_start
);
   localparam int IW = $clog2(NUM_DIGITS);

   typedef struct packed {
      logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
      logic [NUM_DIGITS-1:0]              dp;
   } frame_t;

   logic                  tick, wrap;
   logic [IW-1:0]         idx_q, idx_d;
   frame_t                shadow_q, shadow_d;
   frame_t                active_q, active_d;
   logic [PWM_BITS-1:0]   pwm_q, pwm_d;
   logic                  zero_tail, blank_d, pwm_on, on_d;
   logic [DIGIT_W-1:0]    digit_val_q, digit_val_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic                  dp_q, dp_d;
   logic                  digit_on_q;
   logic                  frame_start_q, frame_start_d;

   scan_tick #(.DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_comb begin
      wrap  = tick && (idx_q == IW'(NUM_DIGITS - 1));
      idx_d = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

      shadow_d = shadow_q;
      if (load) shadow_d = {value, dp_mask};
      // Only the frame wrap publishes the shadow, so a frame never tears.
      active_d = wrap ? shadow_q : active_q;

      pwm_d = pwm_q + 1'b1;
   end

   // Output stage looks at the next index/active so it moves with the index.
   always_comb begin
      zero_tail = 1'b1;
      blank_d   = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_tail = zero_tail && (active_d.digits[i] == DIGIT_W'(BLANK_CODE));
         if (idx_d == IW'(i) && zero_tail) blank_d = lz_suppress;
      end
      pwm_on        = (pwm_q < brightness) || (&brightness);
      on_d          = pwm_on && !blank_d;
      digit_val_d   = active_d.digits[idx_d];
      digit_sel_d   = NUM_DIGITS'(1) << idx_d;
      dp_d          = active_d.dp[idx_d] && on_d;
      frame_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q         <= '0;
         shadow_q      <= '0;
         active_q      <= '0;
         pwm_q         <= '0;
         digit_val_q   <= '0;
         digit_sel_q   <= NUM_DIGITS'(1);
         dp_q          <= 1'b0;
         digit_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pwm_q         <= pwm_d;
         digit_val_q   <= digit_val_d;
         digit_sel_q   <= digit_sel_d;
         dp_q          <= dp_d;
         digit_on_q    <= on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign digit_val   = digit_val_q;
   assign digit_sel   = digit_sel_q;
   assign dp          = dp_q;
   assign digit_on    = digit_on_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: per-frame expectations queued from a
// shadow/active model and popped at each digit slot.
module tb_disp_scan;
   localparam int ND = 8;
   localparam int DW = 4;
   localparam int SD = 4;
   localparam int PB = 4;

   logic             clk, rst_n, load, lz_suppress;
   logic [ND*DW-1:0] value;
   logic [ND-1:0]    dp_mask;
   logic [PB-1:0]    brightness;
   logic [DW-1:0]    digit_val;
   logic [ND-1:0]    digit_sel;
   logic             dp, digit_on, frame_start;

   disp_scan #(.NUM_DIGITS(ND), .DIGIT_W(DW), .SCAN_DIV(SD), .PWM_BITS(PB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp_mask     (dp_mask),
      .load        (load),
      .brightness  (brightness),
      .lz_suppress (lz_suppress),
      .digit_val   (digit_val),
      .digit_sel   (digit_sel),
      .dp          (dp),
      .digit_on    (digit_on),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ND-1:0] sel;
      logic [DW-1:0] val;
      logic          dp;
      logic          on;
      logic          fs;
   } exp_t;

   exp_t             exp_q[$];
   int               n_chk = 0, n_pass = 0, n_fail = 0;
   logic [ND*DW-1:0] ms_val = '0, ma_val = '0;
   logic [ND-1:0]    ms_dp = '0, ma_dp = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input string tag);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 80 && !ok; n++) begin
         @(negedge clk);
         ok = frame_start;
      end
      chk(tag, ok, 1'b1);
   endtask

   // Entered at the negedge where frame_start is visible; returns at the next one.
   task automatic check_frame(input string tag, input int ld_slot, input int ld_off,
                              input logic [ND*DW-1:0] ld_val, input logic [ND-1:0] ld_dp);
      exp_t             e;
      exp_t             r;
      logic             tz;
      logic [ND*DW-1:0] snap_val;
      logic [ND-1:0]    snap_dp;
      logic [ND*DW-1:0] av;
      logic [DW-1:0]    dg;
      av       = ma_val;
      snap_val = ms_val;
      snap_dp  = ms_dp;
      for (int i = 0; i < ND; i++) begin
         tz = 1'b1;
         for (int j = i; j < ND; j++) begin
            dg = av[j*DW +: DW];
            if (dg != '0) tz = 1'b0;
         end
         e.sel = '0;
         e.sel[i] = 1'b1;
         e.val = av[i*DW +: DW];
         e.on  = !(lz_suppress && i > 0 && tz);
         e.dp  = ma_dp[i] && e.on;
         e.fs  = (i == 0);
         exp_q.push_back(e);
      end
      for (int s = 0; s < ND; s++) begin
         for (int o = 0; o < SD; o++) begin
            if (o == 0) begin
               r = exp_q.pop_front();
               chk({tag, "_sel"}, digit_sel, r.sel);
               chk({tag, "_val"}, digit_val, r.val);
               chk({tag, "_dp"},  dp, r.dp);
               chk({tag, "_on"},  digit_on, r.on);
               chk({tag, "_fs"},  frame_start, r.fs);
            end
            if (s == 0 && o == 1) chk({tag, "_fs_width"}, frame_start, 1'b0);
            if (s == ND-1 && o == SD-1) begin
               snap_val = ms_val;
               snap_dp  = ms_dp;
            end
            if (s == ld_slot && o == ld_off) begin
               value   = ld_val;
               dp_mask = ld_dp;
               load    = 1'b1;
               ms_val  = ld_val;
               ms_dp   = ld_dp;
            end else begin
               load = 1'b0;
            end
            @(negedge clk);
         end
      end
      load   = 1'b0;
      ma_val = snap_val;
      ma_dp  = snap_dp;
      chk({tag, "_next_fs"}, frame_start, 1'b1);
   endtask

   initial begin
      int cnt, cdp, n;
      logic ok;
      rst_n = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
      brightness = '1; lz_suppress = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sel", digit_sel, 8'h01);
      chk("rst_val", digit_val, 4'h0);
      chk("rst_dp",  dp, 1'b0);
      chk("rst_on",  digit_on, 1'b0);
      chk("rst_fs",  frame_start, 1'b0);

      rst_n = 1'b1;
      value = 32'h1234_5678; dp_mask = 8'h05; load = 1'b1;
      ms_val = value; ms_dp = dp_mask;
      @(negedge clk);
      load = 1'b0;
      wait_frame("first_frame");
      ma_val = ms_val; ma_dp = ms_dp;

      check_frame("f1234", -1, 0, '0, '0);
      check_frame("midload_old", 3, 1, 32'h9ABC_DEF0, 8'h80);
      check_frame("midload_new", -1, 0, '0, '0);
      check_frame("wrapload_a", ND-1, SD-1, 32'h0000_0405, 8'h00);
      check_frame("wrapload_b", -1, 0, '0, '0);
      lz_suppress = 1'b1;
      check_frame("lz405", 2, 0, 32'h0000_0000, 8'h01);
      check_frame("lz_zero", -1, 0, '0, '0);
      lz_suppress = 1'b0;

      // PWM duty over two full counter periods
      foreach (brightness[k]) begin end
      for (int b = 0; b < 4; b++) begin
         case (b)
            0: brightness = 4'd0;
            1: brightness = 4'd4;
            2: brightness = 4'd8;
            default: brightness = 4'd15;
         endcase
         repeat (2) @(negedge clk);
         cnt = 0; cdp = 0;
         repeat (32) begin
            @(negedge clk);
            cnt += int'(digit_on);
            cdp += int'(dp);
         end
         chk($sformatf("pwm_duty_b%0d", brightness), cnt,
             (brightness == 4'd15) ? 32 : 2 * int'(brightness));
         if (brightness == 4'd0) chk("pwm_dark_dp", cdp, 0);
      end
      brightness = '1;

      wait_frame("pre_rst_frame");
      value = 32'h1111_1111; dp_mask = 8'hFF; load = 1'b1;
      ms_val = value; ms_dp = dp_mask;
      @(negedge clk);
      load = 1'b0;
      wait_frame("pre_rst_frame2");
      ma_val = ms_val; ma_dp = ms_dp;

      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = (digit_sel == 8'h20);
      end
      chk("reach_digit5", ok, 1'b1);
      chk("digit5_val", digit_val, 4'h1);
      rst_n = 1'b0; load = 1'b1; value = 32'h7777_7777; dp_mask = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1; load = 1'b0;
      ms_val = '0; ms_dp = '0; ma_val = '0; ma_dp = '0;
      chk("midrst_sel", digit_sel, 8'h01);
      chk("midrst_on",  digit_on, 1'b0);
      chk("midrst_dp",  dp, 1'b0);
      chk("midrst_val", digit_val, 4'h0);
      chk("midrst_fs",  frame_start, 1'b0);
      repeat (3) @(negedge clk);
      chk("restart_slot0_held", digit_sel, 8'h01);
      @(negedge clk);
      chk("restart_slot1_sel", digit_sel, 8'h02);
      chk("restart_active_clr", digit_val, 4'h0);
      n = 4; ok = 1'b0;
      while (n < 60 && !ok) begin
         @(negedge clk);
         n++;
         ok = frame_start;
      end
      chk("restart_frame_len", n, 32);
      check_frame("post_rst_shadow", -1, 0, '0, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
